// File: rtl/program_mem_controller.sv
// rtl/program_mem_controller.sv - round-robin program memory arbiter, one FSM per channel; watchdog enabled by PROG_MEM_TIMEOUT_EN
module program_mem_controller #(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int NUM_CHANNELS   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
`ifdef PROG_MEM_TIMEOUT_EN
  ,
  output logic                               timeout_error
`endif
);

  typedef enum logic [1:0] {IDLE, WAITING, RELAYING} state_t;

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > NUM_CONSUMERS) begin : g_bad_channels
    $error("NUM_CHANNELS must be in 1..NUM_CONSUMERS");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t               state_q [NUM_CHANNELS];
  state_t               state_d [NUM_CHANNELS];
  logic [IW-1:0]        owner_q [NUM_CHANNELS];
  logic [IW-1:0]        owner_d [NUM_CHANNELS];
  logic [IW-1:0]        ptr_q   [NUM_CHANNELS];
  logic [IW-1:0]        ptr_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] maddr_q [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] maddr_d [NUM_CHANNELS];
  logic [DATA_BITS-1:0] mdata   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mvalid_d;

  logic [NUM_CONSUMERS-1:0] claim_q;
  logic [NUM_CONSUMERS-1:0] claim_d;
  logic [NUM_CONSUMERS-1:0] ready_d;
  logic [DATA_BITS-1:0]     data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     data_d [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     caddr  [NUM_CONSUMERS];

  logic          found;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic [IW:0]   sum;

`ifdef PROG_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q [NUM_CHANNELS];
  logic [TW-1:0] cnt_d [NUM_CHANNELS];
  logic          terr_d;
`endif

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_consumer
    assign caddr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = data_q[g];
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_channel
    assign mdata[g] = mem_read_data[g*DATA_BITS +: DATA_BITS];
    assign mem_read_address[g*ADDR_BITS +: ADDR_BITS] = maddr_q[g];
  end

  // Next state for all channels; channels are evaluated in index order so a
  // claim made by a lower channel is already visible to the higher ones.
  always_comb begin
    claim_d  = claim_q;
    ready_d  = consumer_read_ready;
    mvalid_d = mem_read_valid;
    found    = 1'b0;
    sel      = '0;
    idx      = '0;
    sum      = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) data_d[i] = data_q[i];
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      owner_d[c] = owner_q[c];
      ptr_d[c]   = ptr_q[c];
      maddr_d[c] = maddr_q[c];
    end
`ifdef PROG_MEM_TIMEOUT_EN
    for (int c = 0; c < NUM_CHANNELS; c++) cnt_d[c] = cnt_q[c];
    terr_d = timeout_error;
`endif
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      sel   = '0;
      case (state_q[c])
        IDLE: begin
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            sum = {1'b0, ptr_q[c]} + (IW+1)'(i);
            if (sum >= (IW+1)'(NUM_CONSUMERS)) sum = sum - (IW+1)'(NUM_CONSUMERS);
            idx = sum[IW-1:0];
            if (!found && consumer_read_valid[idx] && !claim_d[idx]) begin
              found = 1'b1;
              sel   = idx;
            end
          end
          if (found) begin
            claim_d[sel] = 1'b1;
            owner_d[c]   = sel;
            mvalid_d[c]  = 1'b1;
            maddr_d[c]   = caddr[sel];
            ptr_d[c]     = (sel == IW'(NUM_CONSUMERS - 1)) ? '0 : sel + 1'b1;
            state_d[c]   = WAITING;
`ifdef PROG_MEM_TIMEOUT_EN
            cnt_d[c]     = '0;
`endif
          end
        end
        WAITING: begin
          if (mem_read_ready[c]) begin
            mvalid_d[c]          = 1'b0;
            ready_d[owner_q[c]]  = 1'b1;
            data_d[owner_q[c]]   = mdata[c];
            state_d[c]           = RELAYING;
          end
`ifdef PROG_MEM_TIMEOUT_EN
          else if (cnt_q[c] >= TW'(TIMEOUT_CYCLES - 1)) begin
            // Memory never answered: hand the fetcher a NOP and flag it.
            mvalid_d[c]         = 1'b0;
            ready_d[owner_q[c]] = 1'b1;
            data_d[owner_q[c]]  = '0;
            terr_d              = 1'b1;
            state_d[c]          = RELAYING;
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
`endif
        end
        RELAYING: begin
          if (!consumer_read_valid[owner_q[c]]) begin
            ready_d[owner_q[c]] = 1'b0;
            claim_d[owner_q[c]] = 1'b0;
            state_d[c]          = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  // Register every channel and consumer-facing output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        owner_q[c] <= '0;
        ptr_q[c]   <= '0;
        maddr_q[c] <= '0;
      end
      for (int i = 0; i < NUM_CONSUMERS; i++) data_q[i] <= '0;
      mem_read_valid      <= '0;
      claim_q             <= '0;
      consumer_read_ready <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        owner_q[c] <= owner_d[c];
        ptr_q[c]   <= ptr_d[c];
        maddr_q[c] <= maddr_d[c];
      end
      for (int i = 0; i < NUM_CONSUMERS; i++) data_q[i] <= data_d[i];
      mem_read_valid      <= mvalid_d;
      claim_q             <= claim_d;
      consumer_read_ready <= ready_d;
    end
  end

`ifdef PROG_MEM_TIMEOUT_EN
  // Per-channel wait counters and the sticky watchdog flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= '0;
      timeout_error <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= cnt_d[c];
      timeout_error <= terr_d;
    end
  end
`endif

endmodule

// File: doc/program_mem_controller.md
Name: program_mem_controller

Overview:
- Arbitrates read-only access to program memory between the per-core instruction fetchers (consumers) and NUM_CHANNELS physical memory channels.
- Sits directly upstream of every fetcher. Answers each fetcher's valid/address request with ready/data, and holds ready until the fetcher withdraws valid.
- One independent FSM per channel. Round-robin consumer selection per channel.

Parameters:
- ADDR_BITS, 8, program memory address width.
- DATA_BITS, 16, instruction word width.
- NUM_CONSUMERS, 4, number of fetchers served (power of 2 not required).
- NUM_CHANNELS, 1, number of concurrent memory channels (1..NUM_CONSUMERS).
- TIMEOUT_CYCLES, 255, watchdog limit; used only with PROG_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- consumer_read_valid  in  NUM_CONSUMERS  per-fetcher request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed addresses; consumer i at bits [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  per-fetcher data-valid.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed returned instructions.
- mem_read_valid  out  NUM_CHANNELS  per-channel request to memory.
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  packed channel addresses.
- mem_read_ready  in  NUM_CHANNELS  memory response strobe.
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  packed memory data.
- timeout_error  out  1  sticky watchdog flag; present only with PROG_MEM_TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0. Every channel in IDLE. Owner and round-robin pointer at 0. All consumer claims cleared.
- Reset during a transaction drops mem_read_valid and consumer_read_ready at once. The memory side must tolerate an abandoned request.
- Channel states: IDLE, WAITING, RELAYING. All outputs are registered.
- IDLE:
  - Scan consumers from the channel's pointer p upward, wrapping modulo NUM_CONSUMERS.
  - Select the first consumer k with valid=1 that is not claimed.
  - Set claim[k] and owner=k. Drive mem_read_valid=1 and mem_read_address=address[k]. Set p=(k+1) mod NUM_CONSUMERS. Go to WAITING.
  - If no consumer qualifies, stay in IDLE.
- Same-cycle contention between channels: the lower-index channel claims first. A higher-index channel must skip any consumer claimed by a lower channel in that same cycle.
- WAITING: on mem_read_ready=1, clear mem_read_valid, drive consumer_read_ready[owner]=1 and consumer_read_data[owner]=mem_read_data, then go to RELAYING.
- RELAYING: hold ready and data until consumer_read_valid[owner]=0. Then clear ready, clear claim[owner] and go to IDLE.
- The address is sampled once, at grant. Address changes while a request is in WAITING are ignored.
- Latency:
  - Request visible at edge N gives mem_read_valid high after edge N.
  - mem_read_ready at edge M gives consumer ready high after edge M.
  - Valid withdrawn at edge R clears ready after edge R. The channel can re-grant from edge R+1.
  - Minimum round trip with single-cycle memory: 3 cycles per fetch.
- consumer_read_data for a consumer holds its last value when not ready; it is not cleared.
- A consumer is never served by two channels at once.
- With NUM_CHANNELS=1, round-robin guarantees each requester is served within NUM_CONSUMERS grants.

Optional Feature:
- Macro: PROG_MEM_TIMEOUT_EN.
- When defined:
  - Each channel has a counter, cleared on entry to WAITING and incremented each cycle in WAITING.
  - When the counter reaches TIMEOUT_CYCLES without mem_read_ready, the channel clears mem_read_valid, returns data 0 (NOP) with ready=1, and enters RELAYING.
  - timeout_error is set to 1 and stays set until reset.
- When undefined: there is no counter and no timeout_error port, and a channel waits in WAITING indefinitely.

Test Plan:
- Single fetch (1 channel, 4 consumers): consumer 2 requests address 0x1A; memory answers 0xB00C one cycle later -> mem_read_address=0x1A; consumer_read_ready[2]=1 with data 0xB00C; ready drops the cycle after valid falls; 3-cycle round trip.
- Round-robin: consumers 0 and 3 request together, pointer at 0 -> consumer 0 served first, then 3. Consumer 0 re-requests at once -> consumer 3 is served before consumer 0's second request.
- Two channels: consumers 1 and 2 request in the same cycle -> channel 0 takes 1, channel 1 takes 2, both mem_read_valid high in the same cycle, no duplicate claim.
- Held ready: the fetcher keeps valid high for 5 cycles after ready -> ready and data stay stable for all 5; no new grant to that consumer.
- Async reset asserted mid-WAITING, between clock edges -> mem_read_valid and all ready bits read 0 before the next edge; after release a new request is granted normally.
- With PROG_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: memory never responds -> ready=1 with data 0x0000 after 4 WAITING cycles; timeout_error=1 and stays 1 until reset.
